store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// Sits directly downstream of the store reservation station and accepts resolved stores
// (value, effective address, ROB tag) when its storeEnable pulses. Each store is held in
// FIFO order until the ROB commits its tag, then written to data memory over a req/ack
// handshake. Completion is broadcast on a CDB-style port.
// PARAMETERS
// DEPTH      4         entries; power of two, >=2
// PTR_W      2         log2(DEPTH)
// invalidNum 6'b010000 "no tag" ROB encoding
// PORTS
// clock          in   1   rising-edge clock
// reset          in   1   asynchronous, active-high
// storeEnable    in   1   push strobe from store RS (one cycle per store)
// data1_in       in   32  store value
// data2_in       in   32  effective address
// robNum_in      in   6   ROB tag of the store
// full           out  1   no free entry; upstream must not push
// commitEnable   in   1   ROB commits tag commitRobNum this cycle
// commitRobNum   in   6   committed tag
// mem_req        out  1   memory write request, held until ack
// mem_addr       out  32  write address
// mem_wdata      out  32  write data
// mem_ack        in   1   memory accepted the write (sampled while mem_req=1)
// iscast_out     out  1   one-cycle completion broadcast
// robNum_out     out  6   tag of the completed store; invalidNum when idle
// ld_addr        in   32  load address probe (STORE_FWD_EN)
// ld_hit         out  1   probe hit (STORE_FWD_EN)
// ld_data        out  32  forwarded value (STORE_FWD_EN)
// BEHAVIOUR
// - Reset: all entries invalid, head=tail=count=0, full=0, mem_req=0, mem_addr=0,
//   mem_wdata=0, iscast_out=0, robNum_out=invalidNum, FSM=IDLE. Reset mid-handshake
//   aborts the write; an ack arriving after reset is ignored.
// - Entry: {valid, committed, value[31:0], addr[31:0], tag[5:0]}.
// - Push: on posedge with storeEnable=1 and full=0, write tail, committed=0, tail++
//   (wraps mod DEPTH). storeEnable while full is dropped; no state change.
// - full is registered: count==DEPTH. A pop and a push in the same cycle keep count
//   unchanged. full is not relieved combinationally by a same-cycle pop.
// - Commit: on commitEnable, every valid entry whose tag equals commitRobNum sets
//   committed=1. An unmatched tag is ignored. A commit in the same cycle as the push of
//   that tag is not seen; the ROB never commits before the push.
// - FSM IDLE: when the head is valid and committed, load mem_addr and mem_wdata from
//   the head, set mem_req=1, and go to REQ (one cycle after commit at the earliest).
// - FSM REQ: hold mem_req, mem_addr and mem_wdata stable. On mem_ack=1, drop mem_req,
//   invalidate the head, head++, count--, and go to DONE. An ack in the same cycle that
//   mem_req first rises counts.
// - FSM DONE: iscast_out=1 and robNum_out=the popped tag for exactly one cycle, then
//   return to IDLE. iscast_out is 0 and robNum_out is invalidNum in every other state.
// - Minimum throughput: one store per 3 cycles. Stores drain strictly in push order. A
//   committed younger entry never bypasses an uncommitted head.
// - mem_ack outside REQ is ignored.
// CONFIGURATION
// - STORE_FWD_EN defined: ld_hit/ld_data are combinational. Search every valid entry,
//   including the one in REQ, whose addr==ld_addr. The youngest match (nearest tail)
//   supplies ld_data and sets ld_hit=1.
// - STORE_FWD_EN undefined: no search logic; ld_hit=0 and ld_data=0 constant. ld_addr is
//   unused.
// TESTING
// - Reset during REQ with mem_req=1 -> mem_req=0, robNum_out=16, full=0 asynchronously;
//   a later ack has no effect.
// - Push tag 5 (val 0xDEADBEEF, addr 0x40), commit 5 -> next cycle mem_req=1,
//   mem_addr=0x40, mem_wdata=0xDEADBEEF. Ack 2 cycles later -> one cycle with
//   iscast_out=1, robNum_out=5.
// - Push tags 1,2,3,4 -> full=1. A 5th push of tag 6 is dropped. Commit 1 and ack ->
//   full=0. Push 6 -> entries drain 2,3,4,6 in order with the tail wrapped.
// - Push 7 then 8; commit 8 only -> no mem_req for 20 cycles. Commit 7 -> 7 is written,
//   then 8.
// - STORE_FWD_EN: push addr 0x80 val 0x11, then addr 0x80 val 0x22; ld_addr=0x80 ->
//   ld_hit=1, ld_data=0x22. ld_addr=0x84 -> ld_hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the store reservation station and
// data memory. Stores are accepted with storeEnable, held until the ROB commits
// their tag, written out over a req/ack handshake, and announced on a one-cycle
// CDB-style broadcast.
// Optional feature macro: STORE_FWD_EN (combinational store-to-load forwarding
// probe on ld_addr / ld_hit / ld_data). Without it ld_hit and ld_data are tied to 0.
module store_buffer #(
  parameter int         DEPTH      = 4,
  parameter int         PTR_W      = 2,
  parameter logic [5:0] invalidNum = 6'b010000
) (
  input  logic        clock,
  input  logic        reset,
  // push side (store reservation station)
  input  logic        storeEnable,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [5:0]  robNum_in,
  output logic        full,
  // commit side (ROB)
  input  logic        commitEnable,
  input  logic [5:0]  commitRobNum,
  // memory write port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  // completion broadcast
  output logic        iscast_out,
  output logic [5:0]  robNum_out,
  // load forwarding probe
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  // entry storage
  logic             valid_reg     [DEPTH];
  logic             committed_reg [DEPTH];
  logic [31:0]      value_reg     [DEPTH];
  logic [31:0]      addr_reg      [DEPTH];
  logic [5:0]       tag_reg       [DEPTH];

  // queue bookkeeping
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             full_reg;

  // write-back FSM and its registered outputs
  state_t           state_reg;
  logic             mem_req_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;
  logic             iscast_reg;
  logic [5:0]       rob_out_reg;

  // per-cycle events
  logic             push;
  logic             pop;
  logic             head_ready;
  logic [DEPTH-1:0] push_sel;
  logic [DEPTH-1:0] pop_sel;
  logic [DEPTH-1:0] commit_sel;

  // A push is only taken when the registered full flag is low; a same-cycle
  // pop does not open a slot for the pushing store.
  assign push = storeEnable && !full_reg;

  // The head leaves the queue on the cycle memory accepts it.
  assign pop = (state_reg == REQ) && mem_ack;

  // The head may be issued once it holds a committed store.
  assign head_ready = valid_reg[head_reg] && committed_reg[head_reg];

  // Per-entry decode of which slot is written, retired or committed this cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_sel
      assign push_sel[gi]   = push && (tail_reg == PTR_W'(gi));
      assign pop_sel[gi]    = pop && (head_reg == PTR_W'(gi));
      assign commit_sel[gi] = commitEnable && valid_reg[gi] &&
                              (tag_reg[gi] == commitRobNum);
    end
  endgenerate

  // Entry array: retire the head, fill the tail, mark tags the ROB committed.
  // Push wins over commit on the same slot so a commit in the push cycle is not seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i]     <= 1'b0;
        committed_reg[i] <= 1'b0;
        value_reg[i]     <= '0;
        addr_reg[i]      <= '0;
        tag_reg[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_sel[i]) begin
          valid_reg[i]     <= 1'b0;
          committed_reg[i] <= 1'b0;
        end else if (push_sel[i]) begin
          valid_reg[i]     <= 1'b1;
          committed_reg[i] <= 1'b0;
          value_reg[i]     <= data1_in;
          addr_reg[i]      <= data2_in;
          tag_reg[i]       <= robNum_in;
        end else if (commit_sel[i]) begin
          committed_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Head/tail pointers (wrap mod DEPTH), occupancy and the registered full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      if (pop) begin
        head_reg <= head_reg + PTR_ONE;
      end
      if (push) begin
        tail_reg <= tail_reg + PTR_ONE;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_FULL);
    end
  end

  // Write-back FSM: issue the committed head, hold the request until ack, then
  // broadcast the retired tag for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      iscast_reg    <= 1'b0;
      rob_out_reg   <= invalidNum;
    end else begin
      case (state_reg)
        IDLE: begin
          iscast_reg  <= 1'b0;
          rob_out_reg <= invalidNum;
          if (head_ready) begin
            mem_req_reg   <= 1'b1;
            mem_addr_reg  <= addr_reg[head_reg];
            mem_wdata_reg <= value_reg[head_reg];
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // address and data stay frozen while waiting for the ack
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            iscast_reg  <= 1'b1;
            rob_out_reg <= tag_reg[head_reg];
            state_reg   <= DONE;
          end
        end
        DONE: begin
          iscast_reg  <= 1'b0;
          rob_out_reg <= invalidNum;
          state_reg   <= IDLE;
        end
        default: begin
          mem_req_reg <= 1'b0;
          iscast_reg  <= 1'b0;
          rob_out_reg <= invalidNum;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign full       = full_reg;
  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign iscast_out = iscast_reg;
  assign robNum_out = rob_out_reg;

`ifdef STORE_FWD_EN
  // Slot index of the k-th oldest entry; walking these in order means the last
  // match found is the youngest store to that address.
  logic [PTR_W-1:0] age_idx [DEPTH];
  logic             fwd_hit;
  logic [31:0]      fwd_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age_idx
      assign age_idx[gi] = head_reg + PTR_W'(gi);
    end
  endgenerate

  // Youngest-match search over all valid entries, including the one in flight.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_reg[age_idx[k]] && (addr_reg[age_idx[k]] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = value_reg[age_idx[k]];
      end
    end
  end

  assign ld_hit  = fwd_hit;
  assign ld_data = fwd_data;
`else
  // No forwarding: the probe port is accepted but ignored.
  logic ld_addr_unused;
  assign ld_addr_unused = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios followed by a randomized run checked
// against a queue-level reference model of the store buffer.
`timescale 1ns/1ps
module tb_store_buffer;

  localparam logic [5:0] INV = 6'd16;

  logic        clock = 1'b0;
  logic        reset;
  logic        storeEnable;
  logic [31:0] data1_in;
  logic [31:0] data2_in;
  logic [5:0]  robNum_in;
  logic        full;
  logic        commitEnable;
  logic [5:0]  commitRobNum;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        iscast_out;
  logic [5:0]  robNum_out;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] val;
    logic [31:0] addr;
    logic [5:0]  tag;
    bit          committed;
  } ent_t;

  ent_t q[$];

  always #5 clock = ~clock;

  store_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .storeEnable (storeEnable),
    .data1_in    (data1_in),
    .data2_in    (data2_in),
    .robNum_in   (robNum_in),
    .full        (full),
    .commitEnable(commitEnable),
    .commitRobNum(commitRobNum),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .iscast_out  (iscast_out),
    .robNum_out  (robNum_out),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [5:0] tag, input logic [31:0] val, input logic [31:0] addr);
    storeEnable = 1'b1;
    data1_in    = val;
    data2_in    = addr;
    robNum_in   = tag;
    tick();
    storeEnable = 1'b0;
  endtask

  task automatic commit(input logic [5:0] tag);
    commitEnable = 1'b1;
    commitRobNum = tag;
    tick();
    commitEnable = 1'b0;
  endtask

  task automatic wait_req(input string name, input int limit);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_req"}, mem_req, 1);
  endtask

  // Expect the head write (tag/val/addr), ack it at once, check the broadcast.
  task automatic drain_one(input string name, input logic [5:0] tag,
                           input logic [31:0] val, input logic [31:0] addr);
    wait_req(name, 10);
    check({name, "_addr"}, mem_addr, addr);
    check({name, "_wdata"}, mem_wdata, val);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({name, "_cast"}, iscast_out, 1);
    check({name, "_tag"}, robNum_out, tag);
    check({name, "_req_drop"}, mem_req, 0);
    tick();
    check({name, "_cast_end"}, iscast_out, 0);
    check({name, "_tag_end"}, robNum_out, INV);
    $display("drain %s tag=%0d addr=0x%0h data=0x%0h", name, tag, addr, val);
  endtask

  initial begin
    int          wait_cnt;
    bit          expect_bcast;
    logic [5:0]  bcast_tag;
    bit          req_now;
    bit          req_prev;
    bit          ack_prev;
    bit          accept;
    logic [5:0]  next_tag;
    bit          exp_hit;
    logic [31:0] exp_data;
    int          cand[$];
    int          pick;

    reset        = 1'b1;
    storeEnable  = 1'b0;
    data1_in     = '0;
    data2_in     = '0;
    robNum_in    = '0;
    commitEnable = 1'b0;
    commitRobNum = '0;
    mem_ack      = 1'b0;
    ld_addr      = '0;

    // ---- reset state ----
    #12;
    check("rst_full", full, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cast", iscast_out, 0);
    check("rst_tag", robNum_out, INV);
    #10 reset = 1'b0;
    tick();

    // ---- single store, commit, delayed ack ----
    push(6'd5, 32'hDEADBEEF, 32'h40);
    commit(6'd5);
    check("t2_req_early", mem_req, 0);
    tick();
    check("t2_req", mem_req, 1);
    check("t2_addr", mem_addr, 32'h40);
    check("t2_wdata", mem_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_req_hold", mem_req, 1);
      check("t2_addr_hold", mem_addr, 32'h40);
      check("t2_cast_wait", iscast_out, 0);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t2_cast", iscast_out, 1);
    check("t2_tag", robNum_out, 5);
    check("t2_req_drop", mem_req, 0);
    tick();
    check("t2_cast_end", iscast_out, 0);
    check("t2_tag_end", robNum_out, INV);
    $display("single store tag=5 done");

    // ---- fill, drop while full, wrap ----
    for (int t = 1; t <= 4; t++) begin
      push(6'(t), 32'hA000 + 32'(t), 32'h100 * 32'(t));
      check("t3_full_fill", full, (t == 4) ? 1 : 0);
    end
    push(6'd6, 32'hBAD, 32'h999);
    check("t3_full_drop", full, 1);
    commit(6'd1);
    drain_one("t3_1", 6'd1, 32'hA001, 32'h100);
    check("t3_full_relief", full, 0);
    push(6'd6, 32'hA006, 32'h600);
    check("t3_full_again", full, 1);
    commit(6'd2);
    commit(6'd3);
    commit(6'd4);
    commit(6'd6);
    drain_one("t3_2", 6'd2, 32'hA002, 32'h200);
    drain_one("t3_3", 6'd3, 32'hA003, 32'h300);
    drain_one("t3_4", 6'd4, 32'hA004, 32'h400);
    drain_one("t3_6", 6'd6, 32'hA006, 32'h600);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_empty_req", mem_req, 0);
    end
    check("t3_empty_full", full, 0);

    // ---- younger commit must not bypass uncommitted head ----
    push(6'd7, 32'hC007, 32'h700);
    push(6'd8, 32'hC008, 32'h800);
    commit(6'd8);
    for (int i = 0; i < 20; i++) begin
      check("t4_no_bypass", mem_req, 0);
      tick();
    end
    commit(6'd7);
    drain_one("t4_7", 6'd7, 32'hC007, 32'h700);
    drain_one("t4_8", 6'd8, 32'hC008, 32'h800);

    // ---- forwarding probe ----
    push(6'd20, 32'h11, 32'h80);
    push(6'd21, 32'h22, 32'h80);
    ld_addr = 32'h80;
    #1;
`ifdef STORE_FWD_EN
    check("fwd_hit", ld_hit, 1);
    check("fwd_data", ld_data, 32'h22);
    ld_addr = 32'h84;
    #1;
    check("fwd_miss", ld_hit, 0);
`else
    check("fwd_off_hit", ld_hit, 0);
    check("fwd_off_data", ld_data, 0);
`endif
    ld_addr = '0;
    commit(6'd20);
    commit(6'd21);
    drain_one("t6_20", 6'd20, 32'h11, 32'h80);
    drain_one("t6_21", 6'd21, 32'h22, 32'h80);

    // ---- asynchronous reset mid-handshake ----
    for (int t = 9; t <= 12; t++) begin
      push(6'(t), 32'hE000 + 32'(t), 32'h1000 + 32'(t));
    end
    check("t5_full", full, 1);
    commit(6'd9);
    wait_req("t5", 10);
    #3 reset = 1'b1;
    #1;
    check("t5_rst_req", mem_req, 0);
    check("t5_rst_tag", robNum_out, INV);
    check("t5_rst_full", full, 0);
    check("t5_rst_addr", mem_addr, 0);
    mem_ack = 1'b1;
    tick();
    tick();
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_late_ack_req", mem_req, 0);
      check("t5_late_ack_cast", iscast_out, 0);
      check("t5_late_ack_full", full, 0);
    end
    mem_ack = 1'b0;
    tick();
    $display("reset mid-handshake done");

    // ---- randomized run against the queue model ----
    q.delete();
    wait_cnt     = 0;
    expect_bcast = 1'b0;
    bcast_tag    = INV;
    req_prev     = 1'b0;
    ack_prev     = 1'b0;
    next_tag     = 6'd0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // observe
      check("rnd_full", full, (q.size() == 4) ? 1 : 0);
      if (expect_bcast) begin
        check("rnd_cast", iscast_out, 1);
        check("rnd_cast_tag", robNum_out, bcast_tag);
        check("rnd_cast_req", mem_req, 0);
        $display("rnd cyc=%0d retired tag=%0d", cyc, bcast_tag);
      end else begin
        check("rnd_nocast", iscast_out, 0);
        check("rnd_nocast_tag", robNum_out, INV);
      end
      if (req_prev && !ack_prev) begin
        check("rnd_req_hold", mem_req, 1);
      end
      if (mem_req === 1'b1) begin
        check("rnd_req_nonempty", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          check("rnd_req_committed", q[0].committed ? 1 : 0, 1);
          check("rnd_addr", mem_addr, q[0].addr);
          check("rnd_wdata", mem_wdata, q[0].val);
        end
      end
      if (q.size() > 0 && q[0].committed && mem_req !== 1'b1) begin
        wait_cnt++;
        check("rnd_req_latency", (wait_cnt > 2) ? 1 : 0, 0);
      end else begin
        wait_cnt = 0;
      end

      // drive
      storeEnable = ($urandom_range(0, 99) < 45);
      data1_in    = $urandom;
      data2_in    = 32'h100 + 32'(4 * $urandom_range(0, 5));
      robNum_in   = next_tag;
      commitEnable = 1'b0;
      if ($urandom_range(0, 99) < 40) begin
        cand.delete();
        foreach (q[i]) if (!q[i].committed) cand.push_back(i);
        if (cand.size() > 0) begin
          pick = ($urandom_range(0, 99) < 60) ? cand[0] : cand[$urandom_range(0, cand.size() - 1)];
          commitEnable = 1'b1;
          commitRobNum = q[pick].tag;
        end else if ($urandom_range(0, 1) == 1) begin
          commitEnable = 1'b1;
          commitRobNum = 6'd40;
        end
      end
      req_now = (mem_req === 1'b1);
      mem_ack = ($urandom_range(0, 99) < 40);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        ld_addr = q[$urandom_range(0, q.size() - 1)].addr;
      end else begin
        ld_addr = 32'h100 + 32'(4 * $urandom_range(0, 6));
      end
      exp_hit  = 1'b0;
      exp_data = '0;
`ifdef STORE_FWD_EN
      foreach (q[i]) begin
        if (q[i].addr == ld_addr) begin
          exp_hit  = 1'b1;
          exp_data = q[i].val;
        end
      end
`endif
      #1;
      check("rnd_ld_hit", ld_hit, exp_hit);
      check("rnd_ld_data", ld_data, exp_data);

      // advance one clock and update the model
      @(posedge clock);
      #1;
      accept = storeEnable && (q.size() < 4);
      if (commitEnable) begin
        foreach (q[i]) if (q[i].tag == commitRobNum) q[i].committed = 1'b1;
      end
      expect_bcast = req_now && mem_ack;
      if (expect_bcast) begin
        bcast_tag = q[0].tag;
        void'(q.pop_front());
      end
      if (accept) begin
        q.push_back('{val: data1_in, addr: data2_in, tag: robNum_in, committed: 1'b0});
        next_tag = (next_tag == 6'd15) ? 6'd0 : next_tag + 6'd1;
      end
      req_prev = req_now;
      ack_prev = mem_ack;
      storeEnable  = 1'b0;
      commitEnable = 1'b0;
      mem_ack      = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
